alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the parallel ALU array (N_ALU slices of WIDTH bits, 3-bit select).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time to the ALU, waits a fixed ALU latency, then captures out, carry_out and the compare flags into a response register with its own valid/ready handshake.

Parameters:
- WIDTH, 4, bits per ALU slice
- N_ALU, 4, number of slices; operand width = WIDTH*N_ALU
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2)
- ALU_LATENCY, 1, cycles between issue-cycle end and ALU result valid (0..7)

Ports:
- clk  in  1  clock, rising edge
- arst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_a  in  WIDTH*N_ALU  operand a
- req_b  in  WIDTH*N_ALU  operand b
- req_sel  in  3  operation select
- alu_a  out  WIDTH*N_ALU  to ALU a
- alu_b  out  WIDTH*N_ALU  to ALU b
- alu_select  out  3  to ALU select
- alu_enable  out  1  to ALU enable
- alu_out  in  WIDTH*N_ALU*8  ALU result
- alu_carry_out  in  1  ALU carry
- alu_a_greater / alu_a_equal / alu_a_less  in  1 each  ALU compare flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_out  out  WIDTH*N_ALU*8  captured result
- rsp_carry  out  1  captured carry
- rsp_flags  out  3  {greater, equal, less}
- rsp_sel  out  3  select of the completed op
- rsp_flag_err  out  1  captured flags not exactly one-hot
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (arst=0, asynchronous):
  - FIFO emptied; FSM to IDLE.
  - All outputs 0, except req_ready=1 immediately after arst rises.
  - Any in-flight or held response is discarded.
- FIFO push: on edge with req_valid&&req_ready.
  - req_ready = !full, from registered count; a same-cycle pop does not raise ready.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: at edge with FIFO non-empty, pop head into operand regs (alu_a/alu_b/alu_select), go to ISSUE. Empty FIFO: stay.
  - ISSUE: alu_enable=1 for exactly this one cycle.
    - ALU_LATENCY=0: capture at end-of-ISSUE edge, go to HOLD.
    - Otherwise: load cnt=ALU_LATENCY-1, go to WAIT.
  - WAIT: cnt decrements each edge. At the edge where cnt==0, capture and go to HOLD.
  - HOLD: rsp_valid=1; rsp_* stable. At edge with rsp_ready=1, go to IDLE.
    - If the FIFO is non-empty, HOLD goes directly to ISSUE instead, popping the next head.
- Operand regs keep their last value outside ISSUE; alu_enable=0 outside ISSUE.
- Capture:
  - rsp_out=alu_out, rsp_carry=alu_carry_out, rsp_sel=issued select.
  - rsp_flags={greater,equal,less}.
  - rsp_flag_err=1 iff popcount(flags)!=1.
- Latency, ALU_LATENCY=1, empty FIFO: request accepted at edge E0 → rsp_valid high after E3.
- One operation in flight, so throughput is 1 op per (2+ALU_LATENCY) cycles with rsp_ready held high.
- Capacity: FIFO_DEPTH queued plus 1 in flight/held.
- Simultaneous push and pop on the same edge is legal when not full; count is unchanged.

Decomposition:
- alu_pkg: alu_sel_t enum (ADD=0, SUB=1, MUL=2, 3-7 reserved, passed through unchanged), issue_state_t enum, alu_req_t struct {a,b,sel}.
- Sub-module alu_req_fifo: parameterised synchronous FIFO with async active-low reset, full/empty and registered count.

Test Plan:
- ADD a=16'h0003, b=16'h0005, ALU model latency 1 → single alu_enable pulse; rsp_valid after E3; rsp_out=8, rsp_sel=0, rsp_flags=3'b001, rsp_flag_err=0.
- MUL a=3, b=7 → rsp_out=21, rsp_sel=2; SUB a=9, b=4 → rsp_out=5, flags=3'b100; responses return in order.
- req_valid held high with rsp_ready=0 → exactly 5 requests accepted; req_ready=0 thereafter; no second alu_enable pulse; rsp_out stable for 10 cycles.
- Release rsp_ready after the 5-deep backlog → 5 responses in order, one alu_enable per op; busy falls after the last handshake.
- arst=0 pulse during WAIT → rsp_valid=0, alu_enable=0, busy=0 immediately; FIFO empty; next request completes normally.
- ALU model drives greater=1 and less=1 → rsp_flag_err=1; ALU_LATENCY=0 build → rsp_valid after E2.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and helpers for the ALU issue stage
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int ALU_N     = 4;
    localparam int ALU_OP_W  = ALU_WIDTH * ALU_N;

    // Selects 3..7 are reserved and travel through the issue stage untouched.
    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2
    } alu_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0] a;
        logic [ALU_OP_W-1:0] b;
        alu_sel_t            sel;
    } alu_req_t;

    function automatic logic flags_err(input logic [2:0] f);
        return !((f == 3'b001) || (f == 3'b010) || (f == 3'b100));
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - request FIFO with registered occupancy count
module alu_req_fifo #(
    parameter int DW    = 35,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues ALU requests, issues one at a time, holds the response
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH       = ALU_WIDTH,
    parameter int N_ALU       = ALU_N,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH*N_ALU-1:0]   req_a,
    input  logic [WIDTH*N_ALU-1:0]   req_b,
    input  logic [2:0]               req_sel,
    output logic [WIDTH*N_ALU-1:0]   alu_a,
    output logic [WIDTH*N_ALU-1:0]   alu_b,
    output logic [2:0]               alu_select,
    output logic                     alu_enable,
    input  logic [WIDTH*N_ALU*8-1:0] alu_out,
    input  logic                     alu_carry_out,
    input  logic                     alu_a_greater,
    input  logic                     alu_a_equal,
    input  logic                     alu_a_less,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH*N_ALU*8-1:0] rsp_out,
    output logic                     rsp_carry,
    output logic [2:0]               rsp_flags,
    output logic [2:0]               rsp_sel,
    output logic                     rsp_flag_err,
    output logic                     busy
);

    localparam int OPW = WIDTH * N_ALU;
    localparam int RW  = OPW * 8;
    localparam int QW  = 2 * OPW + 3;
    localparam logic [2:0] LAT_M1 = (ALU_LATENCY == 0) ? 3'd0 : 3'(ALU_LATENCY - 1);

    issue_state_t   state_q;
    logic [2:0]     cnt_q;
    logic [OPW-1:0] alu_a_q;
    logic [OPW-1:0] alu_b_q;
    logic [2:0]     alu_sel_q;
    logic           alu_en_q;
    logic           rsp_valid_q;
    logic [RW-1:0]  rsp_out_q;
    logic           rsp_carry_q;
    logic [2:0]     rsp_flags_q;
    logic [2:0]     rsp_sel_q;
    logic           rsp_err_q;

    logic           fifo_full;
    logic           fifo_empty;
    logic [QW-1:0]  fifo_head;
    logic           pop;
    logic           do_capture;
    logic [2:0]     cap_flags;

    // Ready is held low while reset is asserted so nothing is accepted mid-reset.
    assign req_ready = arst && !fifo_full;

    alu_req_fifo #(
        .DW    (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (req_valid && req_ready),
        .push_data ({req_a, req_b, req_sel}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp_ready));

    assign do_capture = ((state_q == ST_ISSUE) && (ALU_LATENCY == 0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 3'd0));

    assign cap_flags = {alu_a_greater, alu_a_equal, alu_a_less};

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_flags_q <= '0;
            rsp_sel_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            alu_en_q <= 1'b0;
            if (do_capture) begin
                rsp_out_q   <= alu_out;
                rsp_carry_q <= alu_carry_out;
                rsp_flags_q <= cap_flags;
                rsp_err_q   <= flags_err(cap_flags);
                rsp_sel_q   <= alu_sel_q;
                rsp_valid_q <= 1'b1;
            end
            if (pop) begin
                {alu_a_q, alu_b_q, alu_sel_q} <= fifo_head;
                alu_en_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ALU_LATENCY == 0) begin
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q   <= LAT_M1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= pop ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_select   = alu_sel_q;
    assign alu_enable   = alu_en_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_out      = rsp_out_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_flags    = rsp_flags_q;
    assign rsp_sel      = rsp_sel_q;
    assign rsp_flag_err = rsp_err_q;
    assign busy         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl (latency 1 and latency 0 builds)
module tb_alu_issue_ctrl;

    localparam int OPW = 16;
    localparam int RW  = 128;

    typedef struct packed {
        logic [RW-1:0] out;
        logic          carry;
        logic [2:0]    flags;
        logic          err;
        logic [2:0]    sel;
    } rsp_t;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic bad_flags = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   en1 = 0;

    always #5 clk = ~clk;

    // latency-1 DUT
    logic           req_valid = 1'b0, req_ready, rsp_ready = 1'b0;
    logic [OPW-1:0] req_a = '0, req_b = '0, alu_a, alu_b;
    logic [2:0]     req_sel = '0, alu_select, rsp_flags, rsp_sel;
    logic           alu_enable, alu_carry_out, alu_gt, alu_eq, alu_lt;
    logic [RW-1:0]  alu_out, rsp_out;
    logic           rsp_valid, rsp_carry, rsp_flag_err, busy;

    // latency-0 DUT
    logic           req_valid0 = 1'b0, req_ready0, rsp_ready0 = 1'b0;
    logic [OPW-1:0] req_a0 = '0, req_b0 = '0, alu_a0, alu_b0;
    logic [2:0]     req_sel0 = '0, alu_select0, rsp_flags0, rsp_sel0;
    logic           alu_enable0, alu_carry_out0, alu_gt0, alu_eq0, alu_lt0;
    logic [RW-1:0]  alu_out0, rsp_out0;
    logic           rsp_valid0, rsp_carry0, rsp_flag_err0, busy0;

    alu_issue_ctrl #(.WIDTH(4), .N_ALU(4), .FIFO_DEPTH(4), .ALU_LATENCY(1)) dut (
        .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out),
        .alu_a_greater(alu_gt), .alu_a_equal(alu_eq), .alu_a_less(alu_lt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_carry(rsp_carry), .rsp_flags(rsp_flags), .rsp_sel(rsp_sel),
        .rsp_flag_err(rsp_flag_err), .busy(busy)
    );

    alu_issue_ctrl #(.WIDTH(4), .N_ALU(4), .FIFO_DEPTH(4), .ALU_LATENCY(0)) dut0 (
        .clk(clk), .arst(arst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_a(req_a0), .req_b(req_b0), .req_sel(req_sel0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_select(alu_select0), .alu_enable(alu_enable0),
        .alu_out(alu_out0), .alu_carry_out(alu_carry_out0),
        .alu_a_greater(alu_gt0), .alu_a_equal(alu_eq0), .alu_a_less(alu_lt0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_out(rsp_out0),
        .rsp_carry(rsp_carry0), .rsp_flags(rsp_flags0), .rsp_sel(rsp_sel0),
        .rsp_flag_err(rsp_flag_err0), .busy(busy0)
    );

    function automatic rsp_t ref_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                    input logic [2:0] sel, input logic bad);
        rsp_t r;
        logic [OPW:0]   s;
        logic [2*OPW-1:0] p;
        r = '0;
        r.sel = sel;
        case (sel)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r.out = RW'(s[OPW-1:0]); r.carry = s[OPW]; end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r.out = RW'(s[OPW-1:0]); r.carry = s[OPW]; end
            3'd2: begin p = {16'b0, a} * {16'b0, b}; r.out = RW'(p); end
            default: r.out = RW'({a, b});
        endcase
        r.flags = {a > b, a == b, a < b};
        if (bad) begin
            r.flags[2] = 1'b1;
            r.flags[0] = 1'b1;
        end
        r.err = ($countones(r.flags) != 1);
        return r;
    endfunction

    // ALU stand-in: result valid only in the cycle(s) it should be sampled, garbage otherwise.
    rsp_t stub1_q, stub0;
    logic stub1_v_q;
    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            stub1_v_q <= 1'b0;
            stub1_q   <= '0;
        end else begin
            stub1_v_q <= alu_enable;
            if (alu_enable) stub1_q <= ref_op(alu_a, alu_b, alu_select, bad_flags);
        end
    end
    assign alu_out       = stub1_v_q ? stub1_q.out : {8{16'hDEAD}};
    assign alu_carry_out = stub1_v_q ? stub1_q.carry : 1'b1;
    assign {alu_gt, alu_eq, alu_lt} = stub1_v_q ? stub1_q.flags : 3'b111;

    assign stub0          = ref_op(alu_a0, alu_b0, alu_select0, 1'b0);
    assign alu_out0       = alu_enable0 ? stub0.out : {8{16'hBEEF}};
    assign alu_carry_out0 = alu_enable0 ? stub0.carry : 1'b1;
    assign {alu_gt0, alu_eq0, alu_lt0} = alu_enable0 ? stub0.flags : 3'b111;

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    rsp_t exp_q[$];

    always @(negedge clk) begin
        if (arst && req_valid && req_ready) exp_q.push_back(ref_op(req_a, req_b, req_sel, bad_flags));
        if (alu_enable) en1++;
    end

    always @(negedge clk) begin
        rsp_t e;
        if (arst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("rsp_out", rsp_out, e.out);
                check_val("rsp_carry", RW'(rsp_carry), RW'(e.carry));
                check_val("rsp_flags", RW'(rsp_flags), RW'(e.flags));
                check_val("rsp_flag_err", RW'(rsp_flag_err), RW'(e.err));
                check_val("rsp_sel", RW'(rsp_sel), RW'(e.sel));
            end
        end
    end

    task automatic send(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic [2:0] s);
        int n;
        req_a = a; req_b = b; req_sel = s; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        if (!req_ready) check_val("send_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) check_val("drain_timeout", RW'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    logic [OPW-1:0] tbl_a [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
    logic [OPW-1:0] tbl_b [6] = '{16'h0001, 16'h0002, 16'h0033, 16'h0050, 16'h0005, 16'h0006};
    logic [2:0]     tbl_s [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd6, 3'd1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, acc;
        logic [RW-1:0] snap;

        repeat (3) @(negedge clk);
        check_val("rst_req_ready", RW'(req_ready), 0);
        check_val("rst_rsp_valid", RW'(rsp_valid), 0);
        check_val("rst_alu_enable", RW'(alu_enable), 0);
        check_val("rst_busy", RW'(busy), 0);
        check_val("rst_alu_a", RW'(alu_a), 0);
        check_val("rst_rsp_out", rsp_out, 0);
        @(posedge clk); #1 arst = 1'b1;
        #1 check_val("post_rst_req_ready", RW'(req_ready), 1);
        rsp_ready = 1'b1;

        // single ADD latency
        e0 = en1;
        send(16'h0003, 16'h0005, 3'd0);
        repeat (3) @(negedge clk);
        check_val("lat1_before_e3", RW'(rsp_valid), 0);
        @(negedge clk);
        check_val("lat1_after_e3", RW'(rsp_valid), 1);
        wait_drain();
        check_val("single_enable_pulse", RW'(en1 - e0), 1);

        // back-to-back ops, carry and reserved select
        send(16'h0003, 16'h0007, 3'd2);
        send(16'h0009, 16'h0004, 3'd1);
        send(16'hFFFF, 16'h0001, 3'd0);
        send(16'h1234, 16'h00AB, 3'd5);
        wait_drain();

        // fill backlog while response is held
        rsp_ready = 1'b0;
        e0 = en1;
        acc = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            req_a = tbl_a[acc]; req_b = tbl_b[acc]; req_sel = tbl_s[acc];
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check_val("backlog_accepted", RW'(acc), 5);
        check_val("backlog_req_ready", RW'(req_ready), 0);
        check_val("backlog_one_enable", RW'(en1 - e0), 1);
        @(negedge clk);
        snap = rsp_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("hold_rsp_valid", RW'(rsp_valid), 1);
            check_val("hold_rsp_out", rsp_out, snap);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();
        check_val("backlog_enables", RW'(en1 - e0), 5);
        @(negedge clk);
        check_val("busy_after_drain", RW'(busy), 0);

        // reset in WAIT
        @(posedge clk); #1;
        send(16'h0001, 16'h0002, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #2 arst = 1'b0;
        #1;
        check_val("arst_rsp_valid", RW'(rsp_valid), 0);
        check_val("arst_alu_enable", RW'(alu_enable), 0);
        check_val("arst_busy", RW'(busy), 0);
        exp_q.delete();
        @(posedge clk); #1 arst = 1'b1;
        #1 check_val("arst_release_ready", RW'(req_ready), 1);
        check_val("arst_fifo_empty_busy", RW'(busy), 0);
        send(16'h0004, 16'h0004, 3'd1);
        wait_drain();

        // two flags at once
        bad_flags = 1'b1;
        send(16'h0002, 16'h0005, 3'd0);
        wait_drain();
        bad_flags = 1'b0;

        // latency-0 build
        rsp_ready0 = 1'b1;
        req_a0 = 16'h0003; req_b0 = 16'h0005; req_sel0 = 3'd0; req_valid0 = 1'b1;
        @(negedge clk);
        check_val("lat0_req_ready", RW'(req_ready0), 1);
        @(posedge clk); #1 req_valid0 = 1'b0;
        repeat (2) @(negedge clk);
        check_val("lat0_before_e2", RW'(rsp_valid0), 0);
        @(negedge clk);
        check_val("lat0_after_e2", RW'(rsp_valid0), 1);
        check_val("lat0_rsp_out", rsp_out0, 128'd8);
        check_val("lat0_rsp_flags", RW'(rsp_flags0), RW'(3'b001));
        check_val("lat0_rsp_sel", RW'(rsp_sel0), 0);
        check_val("lat0_flag_err", RW'(rsp_flag_err0), 0);
        repeat (3) @(negedge clk);
        check_val("lat0_busy_idle", RW'(busy0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
